// File: rtl/req_resp_pkg.sv
// ============================================================================
// Module   : req_resp_pkg
// Brief    : Shared constants, op encoding and helpers for req_resp_mc_engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package req_resp_pkg;

    localparam string c_CNFG_READY_VALID = "READY_VALID";
    localparam string c_CNFG_VALID_READY = "VALID_READY";

    localparam string c_MODE_ECHO = "ECHO";
    localparam string c_MODE_INC  = "INC";
    localparam string c_MODE_INV  = "INV";

    // Widest data path the operation helper supports; callers truncate.
    localparam int c_OP_DATA_W = 64;

    typedef enum logic [1:0] {
        OP_ECHO = 2'd0,
        OP_INC  = 2'd1,
        OP_INV  = 2'd2
    } op_mode_e;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    // Low bits of the result are correct for any narrower width, so INC
    // wraps naturally once the caller truncates.
    function automatic logic [c_OP_DATA_W-1:0] apply_op(
        input op_mode_e                 mode,
        input logic [c_OP_DATA_W-1:0]   data
    );
        case (mode)
            OP_INC:  return data + 64'd1;
            OP_INV:  return ~data;
            default: return data;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/req_resp_fifo.sv
// ============================================================================
// Module   : req_resp_fifo
// Brief    : Synchronous per-channel request FIFO with push/pop/count/full/empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_resp_fifo #(
    parameter int DATA_SIZE = 16,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [DATA_SIZE-1:0]   push_data,
    input  logic                   pop,
    output logic [DATA_SIZE-1:0]   pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [DATA_SIZE-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]        r_wr_ptr;
    logic [c_AW-1:0]        r_rd_ptr;
    logic [$clog2(DEPTH):0] r_count;
    logic                   w_do_push;
    logic                   w_do_pop;

    assign full      = (r_count == ($clog2(DEPTH) + 1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap without a compare.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/req_resp_mc_engine.sv
// ============================================================================
// Module   : req_resp_mc_engine
// Brief    : Multi-channel request/response responder: per-channel FIFOs,
//            round-robin scheduler and fixed-latency operation pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_resp_mc_engine
    import req_resp_pkg::*;
#(
    parameter int    DATA_SIZE = 16,
    parameter int    NUM_CH    = 4,
    parameter int    DEPTH     = 4,
    parameter int    RESP_LAT  = 1,
    parameter string CNFG      = "READY_VALID",
    parameter string MODE      = "ECHO"
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NUM_CH-1:0]           req_valid,
    input  logic [NUM_CH*DATA_SIZE-1:0] req_data,
    output logic [NUM_CH-1:0]           req_ready,
    output logic [NUM_CH-1:0]           resp_valid,
    output logic [NUM_CH*DATA_SIZE-1:0] resp_data,
    output logic [NUM_CH-1:0]           proto_err
);

    localparam int       c_CH_W  = clog2_min1(NUM_CH);
    localparam int       c_CNT_W = $clog2(DEPTH) + 1;
    localparam bit       c_VR    = (CNFG == c_CNFG_VALID_READY);
    localparam op_mode_e c_OP    = (MODE == c_MODE_INC) ? OP_INC :
                                   (MODE == c_MODE_INV) ? OP_INV : OP_ECHO;

    if (CNFG != c_CNFG_READY_VALID && CNFG != c_CNFG_VALID_READY) begin : g_bad_cnfg
        $fatal(1, "req_resp_mc_engine: illegal CNFG");
    end
    if (MODE != c_MODE_ECHO && MODE != c_MODE_INC && MODE != c_MODE_INV) begin : g_bad_mode
        $fatal(1, "req_resp_mc_engine: illegal MODE");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "req_resp_mc_engine: DEPTH must be a power of two >= 2");
    end
    if (RESP_LAT < 1) begin : g_bad_lat
        $fatal(1, "req_resp_mc_engine: RESP_LAT must be >= 1");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_nch
        $fatal(1, "req_resp_mc_engine: NUM_CH must be 1..16");
    end
    if (DATA_SIZE < 1 || DATA_SIZE > c_OP_DATA_W) begin : g_bad_dw
        $fatal(1, "req_resp_mc_engine: DATA_SIZE out of range");
    end

    logic [DATA_SIZE-1:0]        w_fifo_dout  [NUM_CH];
    logic [c_CNT_W-1:0]          w_fifo_count [NUM_CH];
    logic [NUM_CH-1:0]           w_fifo_full;
    logic [NUM_CH-1:0]           w_fifo_empty;
    logic [NUM_CH-1:0]           w_space;
    logic [NUM_CH-1:0]           w_push;
    logic [NUM_CH-1:0]           w_pop;
    logic [NUM_CH-1:0]           w_violation;

    logic [c_CH_W-1:0]           r_ptr;
    logic                        w_grant;
    logic [c_CH_W-1:0]           w_grant_idx;
    logic [DATA_SIZE-1:0]        w_op_data;

    logic                        w_fin_valid;
    logic [c_CH_W-1:0]           w_fin_ch;
    logic [DATA_SIZE-1:0]        w_fin_data;

    logic [NUM_CH-1:0]           r_resp_valid;
    logic [NUM_CH*DATA_SIZE-1:0] r_resp_data;
    logic [NUM_CH-1:0]           r_proto_err;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Space comes from the registered count only; a same-cycle pop
        // never opens a slot for a push.
        assign w_space[i] = (w_fifo_count[i] < c_CNT_W'(DEPTH));

        req_resp_fifo #(
            .DATA_SIZE (DATA_SIZE),
            .DEPTH     (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rstn      (rstn),
            .push      (w_push[i]),
            .push_data (req_data[i*DATA_SIZE +: DATA_SIZE]),
            .pop       (w_pop[i]),
            .pop_data  (w_fifo_dout[i]),
            .count     (w_fifo_count[i]),
            .full      (w_fifo_full[i]),
            .empty     (w_fifo_empty[i])
        );
    end

    assign w_push      = req_valid & w_space;
    assign req_ready   = c_VR ? (req_valid & w_space) : w_space;
    assign w_violation = c_VR ? '0 : (req_valid & w_fifo_full);

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int                v_idx;
        logic [c_CH_W-1:0] v_sel;
        w_grant     = 1'b0;
        w_grant_idx = r_ptr;
        v_idx       = 0;
        v_sel       = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NUM_CH) begin
                v_idx = v_idx - NUM_CH;
            end
            v_sel = c_CH_W'(v_idx);
            if (!w_grant && !w_fifo_empty[v_sel]) begin
                w_grant     = 1'b1;
                w_grant_idx = v_sel;
            end
        end
    end

    assign w_pop     = w_grant ? (NUM_CH'(1) << w_grant_idx) : '0;
    assign w_op_data = DATA_SIZE'(apply_op(c_OP, c_OP_DATA_W'(w_fifo_dout[w_grant_idx])));

    // The output register is the last latency stage; only RESP_LAT-1
    // internal stages sit between grant and output.
    if (RESP_LAT == 1) begin : g_direct
        assign w_fin_valid = w_grant;
        assign w_fin_ch    = w_grant_idx;
        assign w_fin_data  = w_op_data;
    end else begin : g_pipe
        localparam int c_N = RESP_LAT - 1;

        logic                 r_pv [c_N];
        logic [c_CH_W-1:0]    r_pc [c_N];
        logic [DATA_SIZE-1:0] r_pd [c_N];

        always_ff @(posedge clk) begin
            if (!rstn) begin
                for (int s = 0; s < c_N; s++) begin
                    r_pv[s] <= 1'b0;
                    r_pc[s] <= '0;
                    r_pd[s] <= '0;
                end
            end else begin
                r_pv[0] <= w_grant;
                r_pc[0] <= w_grant_idx;
                r_pd[0] <= w_op_data;
                for (int s = 1; s < c_N; s++) begin
                    r_pv[s] <= r_pv[s-1];
                    r_pc[s] <= r_pc[s-1];
                    r_pd[s] <= r_pd[s-1];
                end
            end
        end

        assign w_fin_valid = r_pv[c_N-1];
        assign w_fin_ch    = r_pc[c_N-1];
        assign w_fin_data  = r_pd[c_N-1];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ptr        <= c_CH_W'(NUM_CH - 1);
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_proto_err  <= '0;
        end else begin
            if (w_grant) begin
                r_ptr <= w_grant_idx;
            end
            r_resp_valid <= '0;
            if (w_fin_valid) begin
                r_resp_valid[w_fin_ch]                           <= 1'b1;
                r_resp_data[w_fin_ch*DATA_SIZE +: DATA_SIZE]     <= w_fin_data;
            end
            r_proto_err <= r_proto_err | w_violation;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign proto_err  = r_proto_err;

endmodule

`default_nettype wire

// File: doc/req_resp_mc_engine.md
Name: req_resp_mc_engine

Overview:
Multi-channel request/response responder with a selectable handshake protocol. It accepts requests on NUM_CH independent channels and buffers each channel in its own FIFO. A round-robin scheduler drains the FIFOs into a fixed-latency operation pipeline. Each result returns as a single-cycle response on the originating channel, with no response back-pressure.

Parameters:
DATA_SIZE, 16, width of request and response data.
NUM_CH, 4, number of request/response channels (1..16).
DEPTH, 4, entries per channel FIFO (power of two, >=2).
RESP_LAT, 1, pipeline stages between grant and resp_valid (>=1).
CNFG, "READY_VALID", handshake mode: "READY_VALID" or "VALID_READY".
MODE, "ECHO", data operation: "ECHO", "INC" or "INV".

Ports:
clk  input  1  clock; all logic on rising edge.
rstn  input  1  synchronous active-low reset.
req_valid  input  NUM_CH  per-channel request valid.
req_data  input  NUM_CH*DATA_SIZE  per-channel request data; channel i occupies bits [i*DATA_SIZE +: DATA_SIZE].
req_ready  output  NUM_CH  per-channel ready.
resp_valid  output  NUM_CH  per-channel response valid, one cycle per response.
resp_data  output  NUM_CH*DATA_SIZE  per-channel response data, same packing as req_data.
proto_err  output  NUM_CH  sticky protocol-violation flag per channel.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is synchronous and active-low, sampled on the rising edge of clk.
- Reset values:
  - req_ready=0 in VALID_READY mode; in READY_VALID mode req_ready follows FIFO space, so it is all 1 after reset.
  - resp_valid=0, resp_data=0, proto_err=0.
  - FIFOs empty; pipeline invalid; RR pointer=NUM_CH-1, so channel 0 wins first.
- Reset mid-operation flushes all FIFOs and pipeline stages. Any in-flight response is lost and never emitted.
- Space[i] = (count[i] < DEPTH), computed from registered count. A same-cycle pop does not create space.
- READY_VALID mode:
  - req_ready[i] = space[i], independent of req_valid.
  - Transfer when req_valid[i] && req_ready[i].
  - req_valid[i]=1 while req_ready[i]=0 is a violation: the request is dropped and proto_err[i] is set until reset.
- VALID_READY mode:
  - req_ready[i] = req_valid[i] && space[i] (combinational).
  - req_ready is never high while valid is low.
  - valid held while full is legal stalling; no error is raised.
- Accepted data is written into FIFO i at the accepting edge; count[i] increments.
- Scheduler:
  - Each cycle it grants at most one non-empty channel.
  - Search starts at ptr+1 and wraps modulo NUM_CH; ptr updates to the granted channel.
  - The granted FIFO pops in the same cycle.
- Simultaneous push and pop on one channel leave count unchanged. A full FIFO with a pop still deasserts ready that cycle.
- Operation is applied at the grant stage:
  - ECHO: d.
  - INC: d+1, wrapping modulo 2^DATA_SIZE (0xFFFF -> 0x0000 at DATA_SIZE=16).
  - INV: ~d.
- Pipeline carries {valid, ch_idx, data} through RESP_LAT registers.
- At the final stage, resp_valid[ch_idx]=1 and that channel's resp_data slice is loaded for one cycle.
- Non-responding channels hold resp_valid=0. Their resp_data holds its last value.
- Latency: a request accepted at edge E (cycle T) into an empty system gives resp_valid high in cycle T+1+RESP_LAT.
- Ordering: strictly in order per channel; across channels, RR order.
- Throughput: 1 response/cycle aggregate.
- Illegal CNFG, MODE, DEPTH or RESP_LAT values trigger $fatal at elaboration.

Decomposition:
- Package req_resp_pkg:
  - CNFG and MODE string constants.
  - function apply_op(mode, data).
  - localparam helper for clog2 of DEPTH/NUM_CH.
- Sub-module req_resp_fifo (DATA_SIZE, DEPTH):
  - Synchronous FIFO with push/pop/count/full/empty.
  - Instantiated NUM_CH times.
- Scheduler and pipeline stay in the top.

Test Plan:
- Single request, default parameters, MODE=INC: ch0 sends 0x00FF at cycle 5 -> resp_valid[0]=1 with 0x0100 at cycle 7; no other channel responds.
- Fill: ch1 sends 5 back-to-back with no drain possible (force via 4 channels all loaded) -> req_ready[1]=0 after 4 in-FIFO entries; all 5 responses arrive in order 1,2,3,4,5.
- RR fairness: all 4 channels valid continuously from reset -> response channel sequence 0,1,2,3,0,1,... with one response every cycle.
- READY_VALID violation: hold ch2 full and drive req_valid[2]=1 with data 0xABCD -> proto_err[2]=1 sticky, 0xABCD never responds. In VALID_READY mode the same stimulus leaves proto_err=0 and the data is delivered later.
- Wrap and INV: MODE=INC with 0xFFFF -> 0x0000; MODE=INV with 0x1234 -> 0xEDCB.
- Reset mid-flight: 3 requests queued, rstn=0 for one cycle -> no resp_valid afterwards, all FIFOs empty, and the next grant goes to ch0.
